// File: rtl/plic_pkg.sv
// Shared PLIC register-file types: Dbus payloads, register map bases and the decoded-address record.
package plic_pkg;

    localparam int unsigned DBUS_AW    = 32;
    localparam int unsigned DBUS_DW    = 32;
    localparam int unsigned TGT_IDX_W  = 14;
    localparam int unsigned WORD_IDX_W = 5;
    localparam int unsigned SRC_IDX_W  = 10;

    localparam logic [25:0] PRIO_BASE  = 26'h000_0000;
    localparam logic [25:0] PEND_BASE  = 26'h000_1000;
    localparam logic [25:0] IE_BASE    = 26'h000_2000;
    localparam logic [25:0] IE_STRIDE  = 26'h000_0080;
    localparam logic [25:0] CTX_BASE   = 26'h020_0000;
    localparam logic [25:0] CTX_STRIDE = 26'h000_1000;
    localparam logic [25:0] CLAIM_OFS  = 26'h000_0004;

    typedef struct packed {
        logic [DBUS_AW-1:0] addr;
        logic [DBUS_DW-1:0] w_data;
        logic               w_en;
        logic               req;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [DBUS_DW-1:0] r_data;
        logic               ack;
    } type_peri2dbus_s;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_PRIO,
        RGN_PEND,
        RGN_IE,
        RGN_TH,
        RGN_CLAIM
    } type_plic_rgn_e;

    typedef struct packed {
        type_plic_rgn_e          rgn;
        logic [TGT_IDX_W-1:0]    tgt;
        logic [WORD_IDX_W-1:0]   word;
        logic [SRC_IDX_W-1:0]    src;
        logic                    valid;
    } type_plic_addr_dec_s;

endpackage

// File: rtl/plic_addr_dec.sv
// Combinational decode of a Dbus byte offset into a PLIC register region plus target/word/source index.
module plic_addr_dec
    import plic_pkg::*;
#(
    parameter int unsigned SRC_CNT = 2,
    parameter int unsigned TGT_CNT = 2,
    parameter int unsigned NWORDS  = 1
) (
    input  logic [25:0]         addr_i,
    output type_plic_addr_dec_s dec_o
);

    localparam logic [25:0] SRC_LIM  = 26'(SRC_CNT);
    localparam logic [25:0] TGT_LIM  = 26'(TGT_CNT);
    localparam logic [25:0] WORD_LIM = 26'(NWORDS);
    localparam logic [25:0] PEND_END = PEND_BASE + 26'(4 * NWORDS);

    logic [25:0] prio_src;
    logic [25:0] pend_word;
    logic [25:0] ie_off;
    logic [25:0] ie_tgt;
    logic [25:0] ie_word;
    logic [25:0] ctx_off;
    logic [25:0] ctx_tgt;
    logic [25:0] ctx_ofs;

    always_comb begin
        prio_src  = (addr_i - PRIO_BASE) >> 2;
        pend_word = (addr_i - PEND_BASE) >> 2;
        ie_off    = addr_i - IE_BASE;
        ie_tgt    = ie_off / IE_STRIDE;
        ie_word   = (ie_off % IE_STRIDE) >> 2;
        ctx_off   = addr_i - CTX_BASE;
        ctx_tgt   = ctx_off / CTX_STRIDE;
        ctx_ofs   = ctx_off % CTX_STRIDE;
    end

    // Misaligned offsets and out-of-range indices fall through as RGN_NONE.
    always_comb begin
        dec_o = '0;
        if (addr_i[1:0] == 2'b00) begin
            if (addr_i < PEND_BASE) begin
                if (prio_src <= SRC_LIM) begin
                    dec_o.rgn = RGN_PRIO;
                    dec_o.src = SRC_IDX_W'(prio_src);
                end
            end else if (addr_i < PEND_END) begin
                dec_o.rgn  = RGN_PEND;
                dec_o.word = WORD_IDX_W'(pend_word);
            end else if (addr_i >= IE_BASE && addr_i < CTX_BASE) begin
                if (ie_tgt < TGT_LIM && ie_word < WORD_LIM) begin
                    dec_o.rgn  = RGN_IE;
                    dec_o.tgt  = TGT_IDX_W'(ie_tgt);
                    dec_o.word = WORD_IDX_W'(ie_word);
                end
            end else if (addr_i >= CTX_BASE && ctx_tgt < TGT_LIM) begin
                dec_o.tgt = TGT_IDX_W'(ctx_tgt);
                if (ctx_ofs == '0) begin
                    dec_o.rgn = RGN_TH;
                end else if (ctx_ofs == CLAIM_OFS) begin
                    dec_o.rgn = RGN_CLAIM;
                end
            end
        end
        dec_o.valid = (dec_o.rgn != RGN_NONE);
    end

endmodule

// File: rtl/plic_regs_gen.sv
// Parametrised PLIC register file with one-cycle registered Dbus response.
// Optional PLIC_REG_ERR_EN adds plic_err_o for unmapped/misaligned/pending-write accesses.
module plic_regs_gen
    import plic_pkg::*;
#(
    parameter  int unsigned SRC_CNT = 2,
    parameter  int unsigned TGT_CNT = 2,
    parameter  int unsigned PRIO_W  = 3,
    localparam int unsigned SRC_W   = $clog2(SRC_CNT + 1),
    localparam int unsigned NWORDS  = (SRC_CNT + 32) / 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  type_dbus2peri_s                   dbus2plic_i,
    input  logic                              plic_sel_i,
    output type_peri2dbus_s                   plic2dbus_o,
    input  logic [SRC_CNT-1:0]                irq_pending_i,
    input  logic [TGT_CNT-1:0][SRC_W-1:0]     claim_idx_i,
    output logic [TGT_CNT-1:0][SRC_CNT-1:0]   regs_ie_o,
    output logic [SRC_CNT-1:0][PRIO_W-1:0]    regs_prio_o,
    output logic [TGT_CNT-1:0][PRIO_W-1:0]    regs_prio_th_o,
    output logic [TGT_CNT-1:0]                claim_req_o,
    output logic [TGT_CNT-1:0]                complete_req_o,
    output logic [TGT_CNT-1:0][SRC_W-1:0]     complete_idx_o
`ifdef PLIC_REG_ERR_EN
    ,
    output logic                              plic_err_o
`endif
);

    type_plic_addr_dec_s dec;
    logic                valid;
    logic                rd;
    logic                wr;
    logic [31:0]         rd_word;

    logic                              ack_q, ack_d;
    logic [31:0]                       rdata_q, rdata_d;
    logic [SRC_CNT-1:0][PRIO_W-1:0]    prio_q, prio_d;
    logic [TGT_CNT-1:0][PRIO_W-1:0]    th_q, th_d;
    logic [TGT_CNT-1:0][SRC_CNT-1:0]   ie_q, ie_d;

    plic_addr_dec #(
        .SRC_CNT (SRC_CNT),
        .TGT_CNT (TGT_CNT),
        .NWORDS  (NWORDS)
    ) u_addr_dec (
        .addr_i (dbus2plic_i.addr[25:0]),
        .dec_o  (dec)
    );

    // ack_q blocks a new accept so held requests are served every other cycle.
    assign valid = dbus2plic_i.req & plic_sel_i & ~ack_q;
    assign rd    = valid & ~dbus2plic_i.w_en;
    assign wr    = valid &  dbus2plic_i.w_en;

    // Read mux; bank bit j of word w is source 32*w+j, source 0 and sources above SRC_CNT read 0.
    always_comb begin
        rd_word = '0;
        case (dec.rgn)
            RGN_PRIO: begin
                for (int unsigned s = 1; s <= SRC_CNT; s++) begin
                    if (dec.src == SRC_IDX_W'(s)) rd_word = 32'(prio_q[s-1]);
                end
            end
            RGN_PEND: begin
                for (int unsigned s = 1; s <= SRC_CNT; s++) begin
                    if (dec.word == WORD_IDX_W'(s / 32)) rd_word[s % 32] = irq_pending_i[s-1];
                end
            end
            RGN_IE: begin
                for (int unsigned t = 0; t < TGT_CNT; t++) begin
                    for (int unsigned s = 1; s <= SRC_CNT; s++) begin
                        if (dec.tgt == TGT_IDX_W'(t) && dec.word == WORD_IDX_W'(s / 32))
                            rd_word[s % 32] = ie_q[t][s-1];
                    end
                end
            end
            RGN_TH: begin
                for (int unsigned t = 0; t < TGT_CNT; t++) begin
                    if (dec.tgt == TGT_IDX_W'(t)) rd_word = 32'(th_q[t]);
                end
            end
            RGN_CLAIM: begin
                for (int unsigned t = 0; t < TGT_CNT; t++) begin
                    if (dec.tgt == TGT_IDX_W'(t)) rd_word = 32'(claim_idx_i[t]);
                end
            end
            default: ;
        endcase
    end

    // Register updates and the single-cycle claim/complete strobes of the accept cycle.
    always_comb begin
        prio_d         = prio_q;
        th_d           = th_q;
        ie_d           = ie_q;
        claim_req_o    = '0;
        complete_req_o = '0;
        complete_idx_o = '0;
        ack_d          = valid;
        rdata_d        = rd ? rd_word : '0;
        for (int unsigned t = 0; t < TGT_CNT; t++) begin
            if (dec.tgt == TGT_IDX_W'(t)) begin
                if (wr && dec.rgn == RGN_TH) th_d[t] = dbus2plic_i.w_data[PRIO_W-1:0];
                if (wr && dec.rgn == RGN_CLAIM) begin
                    complete_req_o[t] = 1'b1;
                    complete_idx_o[t] = dbus2plic_i.w_data[SRC_W-1:0];
                end
                if (rd && dec.rgn == RGN_CLAIM) claim_req_o[t] = 1'b1;
                for (int unsigned s = 1; s <= SRC_CNT; s++) begin
                    if (wr && dec.rgn == RGN_IE && dec.word == WORD_IDX_W'(s / 32))
                        ie_d[t][s-1] = dbus2plic_i.w_data[s % 32];
                end
            end
        end
        for (int unsigned s = 1; s <= SRC_CNT; s++) begin
            if (wr && dec.rgn == RGN_PRIO && dec.src == SRC_IDX_W'(s))
                prio_d[s-1] = dbus2plic_i.w_data[PRIO_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            prio_q  <= '0;
            th_q    <= '0;
            ie_q    <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            prio_q  <= prio_d;
            th_q    <= th_d;
            ie_q    <= ie_d;
        end
    end

`ifdef PLIC_REG_ERR_EN
    logic err_q, err_d;

    assign err_d = valid & (~dec.valid | (dec.rgn == RGN_PEND & dbus2plic_i.w_en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign plic_err_o = err_q;
`endif

    assign plic2dbus_o    = '{r_data: rdata_q, ack: ack_q};
    assign regs_prio_o    = prio_q;
    assign regs_prio_th_o = th_q;
    assign regs_ie_o      = ie_q;

    logic unused_sig;
    assign unused_sig = ^{dbus2plic_i.addr[31:26], dbus2plic_i.w_data, dec.valid};

endmodule

// File: tb/tb_plic_regs_gen.sv
// Self-checking bench for plic_regs_gen (SRC_CNT=40, TGT_CNT=3, PRIO_W=3): directed plan plus random accesses vs. a map-level model.
module tb_plic_regs_gen;
    import plic_pkg::*;

    localparam int unsigned SRC = 40;
    localparam int unsigned TGT = 3;
    localparam int unsigned PW  = 3;
    localparam int unsigned SW  = 6;
    localparam int unsigned NW  = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    type_dbus2peri_s           dreq;
    logic                      sel;
    type_peri2dbus_s           rsp;
    logic [SRC-1:0]            irq;
    logic [TGT-1:0][SW-1:0]    cidx;
    logic [TGT-1:0][SRC-1:0]   ie_o;
    logic [SRC-1:0][PW-1:0]    prio_o;
    logic [TGT-1:0][PW-1:0]    th_o;
    logic [TGT-1:0]            creq;
    logic [TGT-1:0]            cpl;
    logic [TGT-1:0][SW-1:0]    cpl_idx;
`ifdef PLIC_REG_ERR_EN
    logic                      err;
`endif

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    int unsigned prio_m [SRC+1];
    int unsigned th_m   [TGT];
    bit          ie_m   [TGT][SRC+1];

    always #5 clk = ~clk;

    plic_regs_gen #(.SRC_CNT(SRC), .TGT_CNT(TGT), .PRIO_W(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dbus2plic_i    (dreq),
        .plic_sel_i     (sel),
        .plic2dbus_o    (rsp),
        .irq_pending_i  (irq),
        .claim_idx_i    (cidx),
        .regs_ie_o      (ie_o),
        .regs_prio_o    (prio_o),
        .regs_prio_th_o (th_o),
        .claim_req_o    (creq),
        .complete_req_o (cpl),
        .complete_idx_o (cpl_idx)
`ifdef PLIC_REG_ERR_EN
        ,
        .plic_err_o     (err)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watchdog: the whole run must finish within a bounded time.
    initial begin
        #1000000;
        if (!done) begin
            errors++;
            $error("FAIL timeout waiting for test completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Region kinds: 0 unmapped, 1 prio, 2 pending, 3 enable, 4 threshold, 5 claim/complete.
    function automatic int classify(input logic [31:0] a, output int unsigned t, output int unsigned x);
        int unsigned o;
        o = 32'(a[25:0]);
        t = 0;
        x = 0;
        if (o % 4 != 0) return 0;
        if (o < 'h1000) begin
            x = o / 4;
            return (x <= SRC) ? 1 : 0;
        end
        if (o >= 'h1000 && o < 'h1000 + 4 * NW) begin
            x = (o - 'h1000) / 4;
            return 2;
        end
        if (o >= 'h2000 && o < 'h200000) begin
            t = (o - 'h2000) / 'h80;
            x = ((o - 'h2000) % 'h80) / 4;
            return (t < TGT && x < NW) ? 3 : 0;
        end
        if (o >= 'h200000) begin
            t = (o - 'h200000) / 'h1000;
            x = (o - 'h200000) % 'h1000;
            if (t >= TGT) return 0;
            if (x == 0) return 4;
            if (x == 4) return 5;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_read(input int k, input int unsigned t, input int unsigned x);
        logic [31:0] r;
        int unsigned s;
        r = '0;
        case (k)
            1: if (x != 0) r = prio_m[x];
            2: for (int j = 0; j < 32; j++) begin
                   s = 32 * x + j;
                   if (s >= 1 && s <= SRC) r[j] = irq[s-1];
               end
            3: for (int j = 0; j < 32; j++) begin
                   s = 32 * x + j;
                   if (s >= 1 && s <= SRC) r[j] = ie_m[t][s];
               end
            4: r = th_m[t];
            5: r = 32'(cidx[t]);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s <= SRC; s++) prio_m[s] = 0;
        for (int t = 0; t < TGT; t++) begin
            th_m[t] = 0;
            for (int s = 0; s <= SRC; s++) ie_m[t][s] = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        logic [SRC-1:0][PW-1:0]  ep;
        logic [TGT-1:0][PW-1:0]  et;
        logic [TGT-1:0][SRC-1:0] ei;
        for (int s = 1; s <= SRC; s++) ep[s-1] = PW'(prio_m[s]);
        for (int t = 0; t < TGT; t++) begin
            et[t] = PW'(th_m[t]);
            for (int s = 1; s <= SRC; s++) ei[t][s-1] = ie_m[t][s];
        end
        chk({tag, "_prio_o"}, prio_o, ep);
        chk({tag, "_th_o"}, th_o, et);
        chk({tag, "_ie_o"}, ie_o, ei);
    endtask

    // One complete access: drive at negedge, strobes checked in the accept cycle, response in the ack cycle.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, output logic [31:0] rdata);
        int                      k;
        int unsigned             t, x, s;
        logic [31:0]             erd;
        logic [TGT-1:0]          ecreq, ecpl;
        logic [TGT-1:0][SW-1:0]  ecidx;
        k      = classify(a, t, x);
        erd    = exp_read(k, t, x);
        ecreq  = '0;
        ecpl   = '0;
        ecidx  = '0;
        if (k == 5 && !we) ecreq[t] = 1'b1;
        if (k == 5 && we) begin
            ecpl[t]  = 1'b1;
            ecidx[t] = wd[SW-1:0];
        end
        @(negedge clk);
        dreq.addr   = a;
        dreq.w_data = wd;
        dreq.w_en   = we;
        dreq.req    = 1'b1;
        sel         = 1'b1;
        #1;
        chk({tag, "_claim_req"}, creq, ecreq);
        chk({tag, "_cpl_req"}, cpl, ecpl);
        chk({tag, "_cpl_idx"}, cpl_idx, ecidx);
        chk({tag, "_ack_pre"}, rsp.ack, 1'b0);
        @(negedge clk);
        rdata = rsp.r_data;
        chk({tag, "_ack"}, rsp.ack, 1'b1);
        chk({tag, "_strobe_in_ack"}, {creq, cpl}, '0);
        if (!we) chk({tag, "_rdata"}, rsp.r_data, erd);
`ifdef PLIC_REG_ERR_EN
        chk({tag, "_err"}, err, (k == 0) || (k == 2 && we));
`endif
        dreq.req = 1'b0;
        if (we) begin
            if (k == 1 && x != 0) prio_m[x] = wd & 32'h7;
            if (k == 4) th_m[t] = wd & 32'h7;
            if (k == 3) begin
                for (int j = 0; j < 32; j++) begin
                    s = 32 * x + j;
                    if (s >= 1 && s <= SRC) ie_m[t][s] = wd[j];
                end
            end
        end
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        int          kind;

        rst_n = 1'b0;
        dreq  = '0;
        sel   = 1'b0;
        irq   = '0;
        cidx  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ack", rsp.ack, 1'b0);
        chk("rst_rdata", rsp.r_data, 32'h0);
        chk("rst_strobes", {creq, cpl, cpl_idx}, '0);
`ifdef PLIC_REG_ERR_EN
        chk("rst_err", err, 1'b0);
`endif
        check_regs("rst");
        rst_n = 1'b1;

        access("rd_prio5", 32'h14, 32'h0, 1'b0, rd);
        access("rd_ie_t2w1", 32'h2104, 32'h0, 1'b0, rd);
        access("rd_th2", 32'h202000, 32'h0, 1'b0, rd);

        access("wr_prio33", 32'h84, 32'hFFFF_FFFF, 1'b1, rd);
        access("rd_prio33", 32'h84, 32'h0, 1'b0, rd);
        chk("prio33_val", rd, 32'h7);
        chk("prio33_port", prio_o[32], 3'd7);

        access("wr_ie_t1w0", 32'h2080, 32'hFFFF_FFFF, 1'b1, rd);
        access("rd_ie_t1w0", 32'h2080, 32'h0, 1'b0, rd);
        chk("ie_t1w0_val", rd, 32'hFFFF_FFFE);
        access("wr_ie_t1w1", 32'h2084, 32'hFFFF_FFFF, 1'b1, rd);
        access("rd_ie_t1w1", 32'h2084, 32'h0, 1'b0, rd);
        chk("ie_t1w1_val", rd, 32'h1FF);
        chk("ie_t1_port", ie_o[1], {SRC{1'b1}});

        cidx[2] = 6'd17;
        access("claim_t2", 32'h202004, 32'h0, 1'b0, rd);
        chk("claim_t2_val", rd, 32'd17);
        access("cpl_t2", 32'h202004, 32'd17, 1'b1, rd);

        // Held request: second write waits out the ack cycle.
        @(negedge clk);
        dreq.addr   = 32'h200000;
        dreq.w_data = 32'd5;
        dreq.w_en   = 1'b1;
        dreq.req    = 1'b1;
        sel         = 1'b1;
        @(negedge clk);
        chk("b2b_ack1", rsp.ack, 1'b1);
        dreq.w_data = 32'd2;
        @(negedge clk);
        chk("b2b_gap", rsp.ack, 1'b0);
        chk("b2b_th_first", th_o[0], 3'd5);
        @(negedge clk);
        chk("b2b_ack2", rsp.ack, 1'b1);
        chk("b2b_th_second", th_o[0], 3'd2);
        dreq.req = 1'b0;
        th_m[0]  = 2;
        @(negedge clk);
        chk("b2b_idle", rsp.ack, 1'b0);

        // Select deasserted: the request must be ignored.
        dreq.addr   = 32'h201000;
        dreq.w_data = 32'd7;
        dreq.w_en   = 1'b1;
        dreq.req    = 1'b1;
        sel         = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("nosel_ack", rsp.ack, 1'b0);
        end
        dreq.req = 1'b0;
        sel      = 1'b1;
        check_regs("nosel");

        access("err_rd_unmapped", 32'h300000, 32'h0, 1'b0, rd);
        chk("err_rd_unmapped_val", rd, 32'h0);
        access("err_wr_pend", 32'h1000, 32'hFFFF_FFFF, 1'b1, rd);
        access("rd_misaligned", 32'h202006, 32'h0, 1'b0, rd);
        chk("misaligned_val", rd, 32'h0);

        for (int i = 0; i < 300; i++) begin
            irq = SRC'({$urandom(), $urandom()});
            for (int t = 0; t < TGT; t++) cidx[t] = SW'($urandom_range(0, SRC));
            kind = int'($urandom_range(0, 6));
            case (kind)
                0: a = 4 * $urandom_range(0, SRC + 2);
                1: a = 'h1000 + 4 * $urandom_range(0, NW);
                2: a = 'h2000 + 'h80 * $urandom_range(0, TGT) + 4 * $urandom_range(0, NW);
                3: a = 'h200000 + 'h1000 * $urandom_range(0, TGT) + 4 * $urandom_range(0, 2);
                4: a = 'h200000 + 'h1000 * $urandom_range(0, TGT - 1) + $urandom_range(1, 3);
                5: a = $urandom();
                default: a = 'h200004 + 'h1000 * $urandom_range(0, TGT - 1);
            endcase
            wd = $urandom();
            access("rand", a, wd, 1'($urandom_range(0, 1)), rd);
        end

        // Reset during the ack cycle drops the response and clears all state.
        @(negedge clk);
        dreq.addr   = 32'h201000;
        dreq.w_data = 32'd6;
        dreq.w_en   = 1'b1;
        dreq.req    = 1'b1;
        @(negedge clk);
        rst_n    = 1'b0;
        dreq.req = 1'b0;
        #1;
        chk("inflight_ack", rsp.ack, 1'b0);
        model_reset();
        check_regs("inflight");
        @(negedge clk);
        rst_n = 1'b1;
        access("post_rst_th1", 32'h201000, 32'h0, 1'b0, rd);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
